complex_to_pixel: RTL and testbench

COMPLEX_TO_PIXEL -- requirements
Module: complex_to_pixel

---
 rtl/complex_to_pixel_if.sv | 36 +++
 rtl/complex_to_pixel.sv | 195 +++++++++++++++++++
 tb/tb_complex_to_pixel.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_to_pixel_if.sv
// complex_to_pixel_if: request/result bundle for complex_to_pixel.
//   ZOOM_RECIPROCAL         unsigned 1/zoom, Q4.28
//   real_center/imag_center signed view centre, Q4.28
//   real_in/imag_in         signed point to map, Q4.28
//   in_valid/in_ready       request handshake
//   out_valid/out_ready     result handshake
//   x_out/y_out/in_view     pixel column/row and in-view flag
// master = requester side, slave = complex_to_pixel.
interface complex_to_pixel_if #(
  parameter int unsigned WORD_LENGTH = 32
);
  logic [31:0]            ZOOM_RECIPROCAL;
  logic [WORD_LENGTH-1:0] real_center;
  logic [WORD_LENGTH-1:0] imag_center;
  logic [WORD_LENGTH-1:0] real_in;
  logic [WORD_LENGTH-1:0] imag_in;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [10:0]            x_out;
  logic [10:0]            y_out;
  logic                   in_view;

  modport master (
    output ZOOM_RECIPROCAL, real_center, imag_center, real_in, imag_in,
           in_valid, out_ready,
    input  in_ready, out_valid, x_out, y_out, in_view
  );

  modport slave (
    input  ZOOM_RECIPROCAL, real_center, imag_center, real_in, imag_in,
           in_valid, out_ready,
    output in_ready, out_valid, x_out, y_out, in_view
  );
endinterface

// File: rtl/complex_to_pixel.sv
// complex_to_pixel: maps a Q4.28 complex point onto a screen pixel for the
// view defined by centre and 1/zoom (3 x 2 units at zoom 1). Constant
// latency: one setup cycle, two 11-cycle restoring divides, then DONE.
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    complex_to_pixel_if.slave (request in, pixel result out)
module complex_to_pixel #(
  parameter int unsigned WORD_LENGTH   = 32,
  parameter int unsigned FRAC          = 28,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480
) (
  input  logic                clk,
  input  logic                reset,
  complex_to_pixel_if.slave   bus
);

  localparam int unsigned WL = WORD_LENGTH;
  // Numerator dx*SCREEN_WIDTH stays below 2^(WL+11); one spare bit.
  localparam int unsigned NW = WL + 12;

  if (FRAC >= WL || SCREEN_WIDTH > 2048 || SCREEN_HEIGHT > 2048) begin : g_param_check
    $error("complex_to_pixel: unsupported parameter combination");
  end

  typedef enum logic [2:0] {IDLE, SETUP, DIV_X, DIV_Y, DONE} state_e;
  state_e state_q, state_d;

  logic [WL-1:0]        rin_q, iin_q, rc_q, ic_q;
  logic [31:0]          zr_q;
  logic [WL-1:0]        rw_q, ih_q;
  logic signed [WL:0]   dx_q, dy_q;
  logic [NW-1:0]        rem_q;
  logic [WL-1:0]        den_q;
  logic [10:0]          quo_q, qx_q;
  logic [3:0]           cnt_q;
  logic                 out_valid_q;
  logic [10:0]          x_q, y_q;
  logic                 in_view_q;
  logic                 in_ready_c;

  // Setup arithmetic on the latched request.
  logic [WL-1:0]        z_w, rw_c, ih_c;
  logic signed [WL-1:0] rmin_c, imax_c;
  logic signed [WL:0]   dx_c, dy_c;
  logic [NW-1:0]        numx_c, numy_c;

  always_comb begin
    z_w    = WL'(zr_q);
    rw_c   = z_w + (z_w << 1);
    ih_c   = z_w << 1;
    rmin_c = $signed(rc_q) - ($signed(rw_c) >>> 1);
    imax_c = $signed(ic_q) + ($signed(ih_c) >>> 1);
    dx_c   = $signed({rin_q[WL-1], rin_q}) - $signed({rmin_c[WL-1], rmin_c});
    dy_c   = $signed({imax_c[WL-1], imax_c}) - $signed({iin_q[WL-1], iin_q});
    numx_c = NW'(dx_c[WL-1:0]) * NW'(SCREEN_WIDTH);
    numy_c = NW'(dy_q[WL-1:0]) * NW'(SCREEN_HEIGHT);
  end

  // One restoring-divide step for quotient bit cnt_q. Out-of-view requests
  // still divide (garbage quotient is discarded by the clamp) to keep latency fixed.
  logic [NW-1:0] sub_c, rem_nx;
  logic [10:0]   quo_nx;

  always_comb begin
    sub_c  = NW'(den_q) << cnt_q;
    rem_nx = rem_q;
    quo_nx = quo_q;
    if (rem_q >= sub_c) begin
      rem_nx = rem_q - sub_c;
      quo_nx = quo_q | (11'd1 << cnt_q);
    end
  end

  // Clamp and view test; quo_q holds the y quotient once in DONE.
  logic [10:0] x_fin, y_fin;
  logic        xin_c, yin_c, inv_fin;

  always_comb begin
    x_fin = qx_q;
    y_fin = quo_q;
    xin_c = 1'b1;
    yin_c = 1'b1;
    if (dx_q[WL]) begin
      x_fin = '0;
      xin_c = 1'b0;
    end else if (dx_q >= $signed({1'b0, rw_q})) begin
      x_fin = 11'(SCREEN_WIDTH - 1);
      xin_c = 1'b0;
    end
    if (dy_q[WL]) begin
      y_fin = '0;
      yin_c = 1'b0;
    end else if (dy_q >= $signed({1'b0, ih_q})) begin
      y_fin = 11'(SCREEN_HEIGHT - 1);
      yin_c = 1'b0;
    end
    inv_fin = xin_c & yin_c;
    if (rw_q == '0 || ih_q == '0) begin
      x_fin   = '0;
      y_fin   = '0;
      inv_fin = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = SETUP;
      end
      SETUP:   state_d = DIV_X;
      DIV_X:   if (cnt_q == 4'd0) state_d = DIV_Y;
      DIV_Y:   if (cnt_q == 4'd0) state_d = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rin_q <= '0; iin_q <= '0; rc_q <= '0; ic_q <= '0; zr_q <= '0;
      rw_q <= '0; ih_q <= '0; dx_q <= '0; dy_q <= '0;
      rem_q <= '0; den_q <= '0; quo_q <= '0; qx_q <= '0; cnt_q <= '0;
      out_valid_q <= 1'b0; x_q <= '0; y_q <= '0; in_view_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            rin_q <= bus.real_in;
            iin_q <= bus.imag_in;
            rc_q  <= bus.real_center;
            ic_q  <= bus.imag_center;
            zr_q  <= bus.ZOOM_RECIPROCAL;
          end
        end
        SETUP: begin
          rw_q  <= rw_c;
          ih_q  <= ih_c;
          dx_q  <= dx_c;
          dy_q  <= dy_c;
          rem_q <= numx_c;
          den_q <= rw_c;
          quo_q <= '0;
          cnt_q <= 4'd10;
        end
        DIV_X: begin
          if (cnt_q == 4'd0) begin
            qx_q  <= quo_nx;
            rem_q <= numy_c;
            den_q <= ih_q;
            quo_q <= '0;
            cnt_q <= 4'd10;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DIV_Y: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        DONE: begin
          // First DONE cycle registers the clamped result and raises
          // out_valid; the handshake can complete from the next cycle on.
          if (!out_valid_q) begin
            x_q         <= x_fin;
            y_q         <= y_fin;
            in_view_q   <= inv_fin;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.in_view   = in_view_q;

endmodule

// File: tb/tb_complex_to_pixel.sv
module tb_complex_to_pixel;

  localparam int SW  = 640;
  localparam int SH  = 480;
  localparam int LAT = 24;

  logic clk;
  logic reset;

  complex_to_pixel_if #(.WORD_LENGTH(32)) bus ();

  complex_to_pixel #(
    .WORD_LENGTH(32),
    .FRAC(28),
    .SCREEN_WIDTH(SW),
    .SCREEN_HEIGHT(SH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z, rc, ic, ri, ii;
    int          ex, ey;
    bit          einv;
    bit          tol;
    string       name;
  } vec_t;

  typedef struct {
    int    ex, ey;
    bit    einv;
    bit    tol;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic longint s32(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  // Reference mapping computed with wide integer arithmetic.
  function automatic void model(input logic [31:0] z, rc, ic, ri, ii,
                                output int ex, output int ey, output bit einv);
    longint rw, ih, rmin, imax, dx, dy;
    bit xin, yin;
    rw   = (longint'(z) * 3) & 64'hFFFF_FFFF;
    ih   = (longint'(z) * 2) & 64'hFFFF_FFFF;
    rmin = s32(s32(rc) - (s32(rw) >>> 1));
    imax = s32(s32(ic) + (s32(ih) >>> 1));
    dx   = s32(ri) - rmin;
    dy   = imax - s32(ii);
    if (rw == 0 || ih == 0) begin
      ex = 0; ey = 0; einv = 1'b0;
      return;
    end
    xin = 1'b1; yin = 1'b1;
    if (dx < 0)        begin ex = 0;      xin = 1'b0; end
    else if (dx >= rw) begin ex = SW - 1; xin = 1'b0; end
    else               ex = int'((dx * SW) / rw);
    if (dy < 0)        begin ey = 0;      yin = 1'b0; end
    else if (dy >= ih) begin ey = SH - 1; yin = 1'b0; end
    else               ey = int'((dy * SH) / ih);
    einv = xin & yin;
  endfunction

  function automatic vec_t mk(input logic [31:0] z, rc, ic, ri, ii,
                              input int ex, ey, input bit einv, input bit tol, input string name);
    vec_t v;
    v.z = z; v.rc = rc; v.ic = ic; v.ri = ri; v.ii = ii;
    v.ex = ex; v.ey = ey; v.einv = einv; v.tol = tol; v.name = name;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int   waitc;
    int   lat;
    exp_t e;
    waitc = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.in_ready !== 1'b1) begin
      check({v.name, "_in_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    bus.ZOOM_RECIPROCAL = v.z;
    bus.real_center     = v.rc;
    bus.imag_center     = v.ic;
    bus.real_in         = v.ri;
    bus.imag_in         = v.ii;
    bus.in_valid        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid        = 1'b0;
    // Inputs changing after acceptance must not disturb the result.
    bus.ZOOM_RECIPROCAL = $urandom;
    bus.real_center     = $urandom;
    bus.imag_center     = $urandom;
    bus.real_in         = $urandom;
    bus.imag_in         = $urandom;
    e.ex = v.ex; e.ey = v.ey; e.einv = v.einv; e.tol = v.tol; e.name = v.name;
    sb.push_back(e);
    check({v.name, "_busy_in_ready"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, "_latency"}, 64'(lat), 64'(LAT));
    if (sb.size() == 0) begin
      check({v.name, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      if (e.tol) begin
        check_tol({e.name, "_x"}, int'(bus.x_out), e.ex, 1);
        check_tol({e.name, "_y"}, int'(bus.y_out), e.ey, 1);
      end else begin
        check({e.name, "_x"}, 64'(bus.x_out), 64'(e.ex));
        check({e.name, "_y"}, 64'(bus.y_out), 64'(e.ey));
      end
      check({e.name, "_in_view"}, 64'(bus.in_view), 64'(e.einv));
    end
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ex, ey;
    bit   einv;
    bit   ok;
    bit   seen;
    vec_t v;
    longint rr, iv, cr, ci;
    logic [31:0] tz;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.ZOOM_RECIPROCAL = '0;
    bus.real_center = '0;
    bus.imag_center = '0;
    bus.real_in = '0;
    bus.imag_in = '0;

    // Directed table with hand-derived expectations (1/zoom = 1.0 unless noted).
    vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 320, 240, 1, 0, "centre"));
    vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, 32'hE800_0000, 32'h1000_0000, 0, 0, 1, 0, "corner"));
    vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, 32'h1800_0000, 32'hF000_0000, 639, 479, 0, 0, "out_of_view"));
    vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, 32'h17FF_FFFF, 32'hF000_0001, 639, 479, 1, 0, "last_inside"));
    vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, 32'hE000_0000, 32'h0, 0, 240, 0, 0, "dx_negative"));
    vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, 32'h0, 32'h1800_0000, 320, 0, 0, 0, "dy_negative"));
    vecs.push_back(mk(32'h0800_0000, 32'h0, 32'h0, 32'h0400_0000, 32'h0400_0000, 426, 120, 1, 0, "zoom2"));
    vecs.push_back(mk(32'h1000_0000, 32'h1000_0000, 32'hF800_0000, 32'h0800_0000, 32'h0, 213, 120, 1, 0, "offset_centre"));
    vecs.push_back(mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, "zero_zoom"));

    // Round trip from pixel_to_complex style coordinates.
    foreach (vecs[k]) ; // keep directed entries first
    for (int xi = 0; xi < 4; xi++) begin
      for (int yi = 0; yi < 2; yi++) begin
        int px, py;
        logic [31:0] r32, i32;
        case (xi)
          0: px = 0;
          1: px = 1;
          2: px = 319;
          default: px = 639;
        endcase
        py = (yi == 0) ? 0 : 479;
        rr = -64'sd402653184 + (longint'(px) * 64'sd805306368) / 64'sd640;
        iv = 64'sd268435456 - (longint'(py) * 64'sd536870912) / 64'sd480;
        r32 = rr[31:0];
        i32 = iv[31:0];
        vecs.push_back(mk(32'h1000_0000, 32'h0, 32'h0, r32, i32, px, py, 1, 1,
                          $sformatf("roundtrip_%0d_%0d", px, py)));
      end
    end

    // Random points against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rc32, ic32, ri32, ii32;
      case ($urandom_range(0, 2))
        0: tz = 32'h1000_0000;
        1: tz = 32'h0800_0000;
        default: tz = 32'h0400_0000;
      endcase
      cr = longint'($urandom_range(0, 32'h2000_0000)) - 64'sd268435456;
      ci = longint'($urandom_range(0, 32'h2000_0000)) - 64'sd268435456;
      rr = cr + longint'($urandom_range(0, 32'h4000_0000)) - 64'sd536870912;
      iv = ci + longint'($urandom_range(0, 32'h4000_0000)) - 64'sd536870912;
      rc32 = cr[31:0]; ic32 = ci[31:0]; ri32 = rr[31:0]; ii32 = iv[31:0];
      model(tz, rc32, ic32, ri32, ii32, ex, ey, einv);
      vecs.push_back(mk(tz, rc32, ic32, ri32, ii32, ex, ey, einv, 0, $sformatf("random_%0d", i)));
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_x", 64'(bus.x_out), 64'd0);
    check("reset_y", 64'(bus.y_out), 64'd0);
    check("reset_in_view", 64'(bus.in_view), 64'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Backpressure: result held with out_ready low for 10 cycles.
    bus.out_ready = 1'b0;
    run_vec(vecs[0]);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      ok = (bus.out_valid === 1'b1) && (bus.in_ready === 1'b0) &&
           (bus.x_out === 11'd320) && (bus.y_out === 11'd240) && (bus.in_view === 1'b1);
      check($sformatf("backpressure_hold_%0d", c), 64'(ok), 64'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("backpressure_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("backpressure_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("idle_hold_x", 64'(bus.x_out), 64'd320);
    check("idle_hold_y", 64'(bus.y_out), 64'd240);
    check("idle_hold_in_view", 64'(bus.in_view), 64'd1);
    bus.out_ready = 1'b1;

    // Reset 5 cycles into a request, with in_valid held during reset.
    @(negedge clk);
    bus.ZOOM_RECIPROCAL = 32'h1000_0000;
    bus.real_center = '0;
    bus.imag_center = '0;
    bus.real_in = 32'h0400_0000;
    bus.imag_in = 32'h0400_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ok = (bus.out_valid === 1'b0) && (bus.x_out === 11'd0) &&
         (bus.y_out === 11'd0) && (bus.in_view === 1'b0);
    check("midreset_outputs_cleared", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("midreset_no_out_valid", 64'(seen), 64'd0);
    check("midreset_x_after", 64'(bus.x_out), 64'd0);

    // Normal operation after reset.
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
